key_event_fifo: RTL and testbench
=================================

// Module: key_event_fifo
// PURPOSE
//  Sits between the hps_io ps2_key port and the rememotech core keyboard inputs (key_ready/key_stroke/key_code).
//  Detects each new key event by a toggle of ps2_key[10] and queues it in a small FIFO.
//  Replays queued events to the core as single-cycle strobes, enforcing a minimum gap between strobes.
//  The gap gives the MTX keyboard matrix time to observe every make/break, even during fast typing bursts.
// PARAMETERS
//  DEPTH       8     FIFO entries; power of two, 2..64
//  GAP_CYCLES  4096  Minimum clk_sys cycles from one key_ready pulse to the next; >=1
// PORTS
//  clk_sys     in   1   System clock, all logic on rising edge
//  reset_n     in   1   Asynchronous active-low reset
//  ps2_key     in   11  [10]=event toggle, [9]=pressed, [8]=extended (E0), [7:0]=scan code
//  ovf_clr     in   1   Clears the sticky overflow flag
//  key_ready   out  1   One-cycle strobe; key_stroke/key_code are valid on this cycle
//  key_stroke  out  1   1 = make, 0 = break
//  key_code    out  10  {1'b0, extended, scan code}
//  fifo_level  out  7   Current number of queued entries, 0..DEPTH
//  overflow    out  1   Sticky; set when an event is dropped because the FIFO is full
// BEHAVIOUR
//  - Reset values: key_ready=0, key_stroke=0, key_code=0, fifo_level=0, overflow=0, FSM=IDLE.
//    The toggle register is reset to 0, and the first edge after reset is captured
//    (hps_io also starts ps2_key[10] at 0).
//  - Capture:
//    - tgl_q <= ps2_key[10] every cycle; an event exists when ps2_key[10]^tgl_q.
//    - Push {ps2_key[9], ps2_key[8:0]} (10 bits) on that same cycle.
//  - FIFO: synchronous circular buffer with wr_ptr/rd_ptr of log2(DEPTH)+1 bits.
//    - Pointers wrap modulo 2*DEPTH; full and empty are decided by MSB compare.
//  - Full: the push is dropped, FIFO contents are unchanged, and overflow<=1.
//    - overflow stays set until ovf_clr=1.
//    - If ovf_clr and a dropping push occur on the same cycle, set wins.
//  - Simultaneous push and pop:
//    - When not full, both occur and the level is unchanged.
//    - When full, the pop frees a slot in the same cycle and the push is ACCEPTED (no overflow).
//  - FSM:
//    - IDLE: if !empty, go to EMIT.
//    - EMIT:
//      - For one cycle: key_ready=1; key_stroke/key_code driven from the head entry.
//      - Pop, load gap_cnt=GAP_CYCLES-1, go to GAP.
//    - GAP: decrement gap_cnt; at 0, go to IDLE.
//  - Latency:
//    - An event into an empty FIFO while in IDLE gives key_ready 2 cycles after the ps2_key[10] toggle.
//    - Cycle 1 = push; cycle 2 = the EMIT cycle, in which key_ready is high.
//    - Back-to-back strobes are spaced exactly GAP_CYCLES+1 cycles apart.
//  - key_stroke and key_code hold their last emitted value between strobes; key_ready is 0 outside EMIT.
//  - Reset asserted mid-operation: FIFO emptied, gap aborted, outputs return to their reset values.
//    Queued events are lost; no strobe is emitted on the cycle reset is released.
// CONFIGURATION
//  - KEY_REPEAT_FILTER_EN defined:
//    - A 10-bit last_make register (valid bit cleared on reset) tracks the most recent accepted make code.
//    - A make event whose {ext, code} equals last_make, with no break for that code since, is discarded before the FIFO.
//    - A discarded event does not set overflow. This suppresses PS/2 typematic repeat.
//    - A break event matching last_make clears valid.
//  - Macro undefined: every event is queued (auto-repeat passes through to the core).
// TESTING
//  1. Reset, then toggle ps2_key[10] with ps2_key[9:0]=10'h21C (make, code 0x1C).
//     Expect key_ready on cycle +2, key_stroke=1, key_code=10'h01C, fifo_level back to 0.
//  2. GAP_CYCLES=16: push 3 events on consecutive cycles.
//     Expect 3 strobes at cycles +2, +19, +36 in push order; fifo_level peaks at 2.
//  3. DEPTH=8: push 10 events while the FSM is held in GAP.
//     Expect overflow=1, the first 8 events emitted, the last 2 lost.
//     Then ovf_clr=1 for one cycle gives overflow=0.
//  4. FIFO full and the EMIT pop on the same cycle as a new push.
//     Expect the push accepted, overflow stays 0, and all events emitted in order.
//  5. Drop reset_n low mid-GAP with 4 entries queued.
//     Expect key_ready=0, fifo_level=0, key_code=0 immediately; no strobe after release.
//  6. KEY_REPEAT_FILTER_EN: send make 0x1C three times, then break 0x1C, then make 0x1C.
//     Expect exactly 3 strobes: make, break, make.
//     Without the macro: 5 strobes.

Source files
------------

// File: rtl/key_event_fifo.sv
// Keyboard event queue between hps_io ps2_key and the core's key_ready/key_stroke/key_code inputs.
// Optional typematic-repeat suppression is compiled in with `define KEY_REPEAT_FILTER_EN.
module key_event_fifo #(
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 4096
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic        ovf_clr,
   output logic        key_ready,
   output logic        key_stroke,
   output logic [9:0]  key_code,
   output logic [6:0]  fifo_level,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);
   localparam logic [GW-1:0] GAP_ZERO = GW'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t        state_q;
   logic [GW-1:0] gap_cnt_q;
   logic          tgl_q;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [6:0]    level_q, level_d;
   logic          ovf_q;
   logic          ready_q;
   logic          stroke_q;
   logic [9:0]    code_q;
   logic [9:0]    mem_q [DEPTH];

   logic          event_s;
   logic          empty_s;
   logic          full_s;
   logic          pop_s;
   logic          discard_s;
   logic          want_push_s;
   logic          push_s;
   logic          drop_s;
   logic [9:0]    head_s;

   assign event_s = ps2_key[10] ^ tgl_q;
   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_s   = (state_q == ST_EMIT);
   assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef KEY_REPEAT_FILTER_EN
   // {valid, extended, scan code} of the most recent queued make
   logic [9:0] last_make_q;
   logic       match_s;

   assign match_s   = last_make_q[9] && (last_make_q[8:0] == ps2_key[8:0]);
   assign discard_s = event_s && ps2_key[9] && match_s;

   // Track the last queued make; a matching break re-arms the filter
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         last_make_q <= 10'd0;
      end else if (push_s && ps2_key[9]) begin
         last_make_q <= {1'b1, ps2_key[8:0]};
      end else if (event_s && !ps2_key[9] && match_s) begin
         last_make_q[9] <= 1'b0;
      end
   end
`else
   assign discard_s = 1'b0;
`endif

   // A full FIFO still accepts a push when the EMIT pop frees a slot this cycle
   assign want_push_s = event_s && !discard_s;
   assign push_s      = want_push_s && (!full_s || pop_s);
   assign drop_s      = want_push_s && full_s && !pop_s;

   // Next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + 7'd1;
         2'b01:   level_d = level_q - 7'd1;
         default: level_d = level_q;
      endcase
   end

   // Edge detector, FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tgl_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= 7'd0;
         ovf_q    <= 1'b0;
      end else begin
         tgl_q    <= ps2_key[10];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         if (drop_s) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // Entry storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk_sys) begin
      if (push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= ps2_key[9:0];
      end
   end

   // Strobe sequencer: output is loaded from the head on entry to EMIT
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         gap_cnt_q <= GAP_ZERO;
         ready_q   <= 1'b0;
         stroke_q  <= 1'b0;
         code_q    <= 10'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!empty_s) begin
                  state_q  <= ST_EMIT;
                  ready_q  <= 1'b1;
                  stroke_q <= head_s[9];
                  code_q   <= {1'b0, head_s[8:0]};
               end else begin
                  ready_q  <= 1'b0;
               end
            end
            ST_EMIT: begin
               ready_q   <= 1'b0;
               gap_cnt_q <= GAP_LOAD;
               state_q   <= (GAP_CYCLES == 1) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
               ready_q <= 1'b0;
               // Leaving on the count of one keeps strobes exactly GAP_CYCLES+1 apart
               if (gap_cnt_q <= GAP_ONE) begin
                  gap_cnt_q <= GAP_ZERO;
                  state_q   <= ST_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_ONE;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               ready_q   <= 1'b0;
               gap_cnt_q <= GAP_ZERO;
            end
         endcase
      end
   end

   assign key_ready  = ready_q;
   assign key_stroke = stroke_q;
   assign key_code   = code_q;
   assign fifo_level = level_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Self-checking bench for key_event_fifo: queue/time-based reference model plus directed literal checks.
module tb_key_event_fifo;

   localparam int DEPTH = 8;
   localparam int GAP   = 16;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b1;
   logic [10:0] ps2_key = 11'd0;
   logic        ovf_clr = 1'b0;
   logic        key_ready;
   logic        key_stroke;
   logic [9:0]  key_code;
   logic [6:0]  fifo_level;
   logic        overflow;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state
   bit [9:0] mq[$];
   bit       m_tgl       = 1'b0;
   bit       m_ready     = 1'b0;
   bit       m_stroke    = 1'b0;
   bit [9:0] m_code      = 10'd0;
   bit       m_ovf       = 1'b0;
   int       last_strobe = -100000;
   bit       lm_valid    = 1'b0;
   bit [8:0] lm_code     = 9'd0;

   // observed strobes
   int       sc[$];
   bit [9:0] scode[$];

   key_event_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .ps2_key    (ps2_key),
      .ovf_clr    (ovf_clr),
      .key_ready  (key_ready),
      .key_stroke (key_stroke),
      .key_code   (key_code),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Model: a strobe fires when the queue is non-empty and at least GAP idle cycles
   // separate it from the previous strobe; the strobed entry leaves one cycle later.
   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_tgl = 1'b0; m_ready = 1'b0; m_stroke = 1'b0; m_code = 10'd0;
         m_ovf = 1'b0; last_strobe = -100000; lm_valid = 1'b0; lm_code = 9'd0;
      end else begin
         int n;
         bit ev, pop, fire, disc, drop;
         bit [9:0] hd;
         n = cyc + 1;
         ev = ps2_key[10] ^ m_tgl;
         m_tgl = ps2_key[10];
         pop = m_ready;
         fire = (mq.size() > 0) && (n - 1 >= last_strobe + GAP);
         if (fire) begin
            hd = mq[0];
            m_stroke = hd[9];
            m_code = {1'b0, hd[8:0]};
            last_strobe = n;
         end
         m_ready = fire;
         if (pop) void'(mq.pop_front());
         disc = 1'b0;
         drop = 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
         disc = ev && ps2_key[9] && lm_valid && (lm_code == ps2_key[8:0]);
`endif
         if (ev && !disc) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(ps2_key[9:0]);
               if (ps2_key[9]) begin
                  lm_valid = 1'b1;
                  lm_code = ps2_key[8:0];
               end
            end else begin
               drop = 1'b1;
            end
         end
         if (ev && !ps2_key[9] && lm_valid && (lm_code == ps2_key[8:0])) lm_valid = 1'b0;
         if (drop) m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
      end
   end

   // Compare every cycle, away from the active edge
   always @(negedge clk_sys) begin
      total++;
      if (key_ready !== m_ready || key_stroke !== m_stroke || key_code !== m_code ||
          fifo_level !== 7'(mq.size()) || overflow !== m_ovf) begin
         bad++;
         $display("FAIL model cyc=%0d: got rdy=%0b stk=%0b code=%h lvl=%0d ovf=%0b expected rdy=%0b stk=%0b code=%h lvl=%0d ovf=%0b",
                  cyc, key_ready, key_stroke, key_code, fifo_level, overflow,
                  m_ready, m_stroke, m_code, mq.size(), m_ovf);
      end
      if (key_ready === 1'b1) begin
         sc.push_back(cyc);
         scode.push_back(key_code);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic send(input bit [9:0] k);
      ps2_key = {~ps2_key[10], k};
      tick();
   endtask

   task automatic wait_strobe(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (key_ready === 1'b1) seen = 1'b1;
      end
      chk(nm, int'(seen), 1);
   endtask

   initial begin
      int t0, n0, k;
      bit [7:0] codes [3];
      codes[0] = 8'h1C; codes[1] = 8'h1D; codes[2] = 8'h5A;

      #1 reset_n = 1'b0;
      repeat (3) tick();
      chk("reset_ready", int'(key_ready), 0);
      chk("reset_level", int'(fifo_level), 0);
      chk("reset_ovf", int'(overflow), 0);
      chk("reset_code", int'(key_code), 0);
      reset_n = 1'b1;
      tick();

      // 1: single make, latency 2
      t0 = cyc;
      send(10'h21C);
      tick();
      chk("t1_ready", int'(key_ready), 1);
      chk("t1_stroke", int'(key_stroke), 1);
      chk("t1_code", int'(key_code), 'h01C);
      repeat (3) tick();
      chk("t1_level", int'(fifo_level), 0);

      // 2: three back-to-back events, strobes GAP+1 apart
      repeat (40) tick();
      t0 = cyc;
      send(10'h201);
      send(10'h202);
      chk("t2_level_peak", int'(fifo_level), 2);
      send(10'h203);
      repeat (60) tick();
      k = -1;
      foreach (sc[i]) if (k < 0 && sc[i] > t0) k = i;
      chk("t2_found", int'(k >= 0 && k + 2 < sc.size()), 1);
      if (k >= 0 && k + 2 < sc.size()) begin
         chk("t2_s1_cyc", sc[k] - t0, 2);
         chk("t2_s2_cyc", sc[k+1] - t0, 19);
         chk("t2_s3_cyc", sc[k+2] - t0, 36);
         chk("t2_s1_code", int'(scode[k]), 'h001);
         chk("t2_s3_code", int'(scode[k+2]), 'h003);
      end

      // 3: overflow while held in GAP
      repeat (40) tick();
      send(10'h230);
      wait_strobe("t3_first_strobe");
      for (int i = 0; i < 10; i++) send(10'h240 + 10'(i));
      chk("t3_ovf_set", int'(overflow), 1);
      chk("t3_level_full", int'(fifo_level), 8);
      n0 = sc.size();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t3_ovf_clr", int'(overflow), 0);
      repeat (8 * 17 + 20) tick();
      chk("t3_strobes", sc.size() - n0, 8);
      if (sc.size() - n0 == 8) begin
         chk("t3_first_code", int'(scode[n0]), 'h040);
         chk("t3_last_code", int'(scode[n0+7]), 'h047);
      end

      // 4: push on the pop cycle of a full FIFO is accepted
      send(10'h250);
      wait_strobe("t4_first_strobe");
      for (int i = 0; i < 8; i++) send(10'h260 + 10'(i));
      chk("t4_full_level", int'(fifo_level), 8);
      chk("t4_full_ovf", int'(overflow), 0);
      wait_strobe("t4_pop_strobe");
      send(10'h270);
      chk("t4_ovf", int'(overflow), 0);
      chk("t4_level", int'(fifo_level), 8);
      repeat (9 * 17 + 20) tick();
      chk("t4_drained", int'(fifo_level), 0);
      chk("t4_last_code", int'(scode[$]), 'h070);

      // random traffic with periodic bursts that overflow
      for (int i = 0; i < 3000; i++) begin
         ovf_clr = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0 || (i % 500) < 30)
            ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       codes[$urandom_range(0, 2)]};
         tick();
      end
      ovf_clr = 1'b0;

      // 5: reset mid-GAP with entries queued
      repeat (300) tick();
      send(10'h2AA);
      wait_strobe("t5_first_strobe");
      for (int i = 0; i < 4; i++) send(10'h2B0 + 10'(i));
      chk("t5_level_before", int'(fifo_level), 4);
      reset_n = 1'b0;
      ps2_key = 11'd0;
      #1;
      chk("t5_ready", int'(key_ready), 0);
      chk("t5_level", int'(fifo_level), 0);
      chk("t5_code", int'(key_code), 0);
      repeat (2) tick();
      reset_n = 1'b1;
      n0 = sc.size();
      repeat (60) tick();
      chk("t5_no_strobe", sc.size() - n0, 0);

      // 6: typematic repeat
      n0 = sc.size();
      send(10'h21C);
      send(10'h21C);
      send(10'h21C);
      send(10'h01C);
      send(10'h21C);
      repeat (5 * 17 + 20) tick();
`ifdef KEY_REPEAT_FILTER_EN
      chk("t6_strobes", sc.size() - n0, 3);
`else
      chk("t6_strobes", sc.size() - n0, 5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
